// File: rtl/mem_word_sequencer_if.sv
// Bundle of the CPU request/response handshake and the byte-wide memory port
// for the load/store sequencer.
interface mem_word_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;

  logic              resp_valid;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;

  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  // CPU datapath plus memory model side
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/mem_word_sequencer.sv
// Splits byte/halfword/word loads and stores into little-endian single-byte
// memory accesses and returns the extended load result as a one-cycle pulse.
module mem_word_sequencer #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 32
) (
  input logic                  clk,
  input logic                  rst,
  mem_word_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic              signed_q, signed_d;
  logic [1:0]        size_q, size_d;
  logic              err_q, err_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic              req_err;
  logic [4:0]        lane_lsb;

  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      SZ_BYTE: last_idx = 2'd0;
      SZ_HALF: last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction

  assign req_err = (bus.req_size == 2'd3)
                 || (bus.req_size == SZ_HALF && bus.req_addr[0])
                 || (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00);

  assign lane_lsb = {cnt_q, 3'b000};

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    write_d  = write_q;
    signed_d = signed_q;
    size_d   = size_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          signed_d = bus.req_signed;
          size_d   = bus.req_size;
          wdata_d  = bus.req_wdata;
          rdata_d  = '0;
          cnt_d    = 2'd0;
          err_d    = req_err;
          if (req_err) begin
            // Rejected requests never touch the memory port, so mem_addr holds.
            state_d = RESP;
          end else begin
            state_d = ACCESS;
            addr_d  = bus.req_addr;
          end
        end
      end
      ACCESS: begin
        if (!write_q) rdata_d[lane_lsb +: 8] = bus.mem_rdata;
        if (cnt_q == last_idx(size_q)) begin
          state_d = RESP;
        end else begin
          cnt_d  = cnt_q + 2'd1;
          addr_d = addr_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'd0;
      err_q    <= 1'b0;
      cnt_q    <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      signed_q <= signed_d;
      size_q   <= size_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // Outputs decode registered state only, so mem_write falls as soon as rst rises.
  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.resp_err   = (state_q == RESP) && err_q;
    bus.mem_write  = (state_q == ACCESS) && write_q;
    bus.mem_addr   = addr_q;
    bus.mem_wdata  = bus.mem_write ? wdata_q[lane_lsb +: 8] : 8'h00;

    bus.resp_rdata = '0;
    if (state_q == RESP && !write_q && !err_q) begin
      case (size_q)
        SZ_BYTE: bus.resp_rdata = {{(WORD_W-8){signed_q & rdata_q[7]}}, rdata_q[7:0]};
        SZ_HALF: bus.resp_rdata = {{(WORD_W-16){signed_q & rdata_q[15]}}, rdata_q[15:0]};
        default: bus.resp_rdata = rdata_q;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_word_sequencer.sv
// Scoreboard bench for mem_word_sequencer: a byte-array memory model answers
// the memory port, and expected responses are queued as requests are accepted.
module tb_mem_word_sequencer;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   wr_cnt;
  int   resp_cnt;

  logic [7:0] mem [256];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];

  mem_word_sequencer_if #(.ADDR_W(8), .WORD_W(32)) bus ();

  mem_word_sequencer #(.ADDR_W(8), .WORD_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;

  assign bus.mem_rdata = mem[bus.mem_addr];

  // Response monitor: pops the scoreboard on every resp_valid pulse.
  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_write) wr_cnt++;
    if (bus.resp_valid) begin
      resp_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got resp_valid at cycle %0d, required none", cyc);
      end else begin
        e = sb.pop_front();
        if (bus.resp_rdata !== e.rdata) begin
          errors++;
          $display("FAIL resp_rdata: got %h, required %h", bus.resp_rdata, e.rdata);
        end
        checks++;
        if (bus.resp_err !== e.err) begin
          errors++;
          $display("FAIL resp_err: got %b, required %b", bus.resp_err, e.err);
        end
        checks++;
        if (cyc - e.acc_cyc + 1 != e.lat) begin
          errors++;
          $display("FAIL resp_latency: got %0d, required %0d", cyc - e.acc_cyc + 1, e.lat);
        end
      end
    end
  end

  // Drives one request from a negedge; returns on the negedge after acceptance.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [7:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                       input bit expect_resp, input bit hold, output int acc_cyc);
    exp_t e;
    int   waited;
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    waited = 0;
    while (!bus.req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 after %0d cycles, required 1", waited);
      bus.req_valid = 1'b0;
      acc_cyc = -1;
      return;
    end
    acc_cyc = cyc + 1;
    if (expect_resp) begin
      e.rdata   = exp_rd;
      e.err     = exp_err;
      e.lat     = exp_lat;
      e.acc_cyc = acc_cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending responses, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_byte(input string name, input logic [7:0] a, input logic [7:0] exp);
    checks++;
    if (mem[a] !== exp) begin
      errors++;
      $display("FAIL %s: mem[%h] got %h, required %h", name, a, mem[a], exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks += 7;
    if (bus.req_ready  !== 1'b1)  begin errors++; $display("FAIL rst_req_ready: got %b, required 1", bus.req_ready); end
    if (bus.resp_valid !== 1'b0)  begin errors++; $display("FAIL rst_resp_valid: got %b, required 0", bus.resp_valid); end
    if (bus.resp_err   !== 1'b0)  begin errors++; $display("FAIL rst_resp_err: got %b, required 0", bus.resp_err); end
    if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata: got %h, required 0", bus.resp_rdata); end
    if (bus.mem_write  !== 1'b0)  begin errors++; $display("FAIL rst_mem_write: got %b, required 0", bus.mem_write); end
    if (bus.mem_addr   !== 8'h0)  begin errors++; $display("FAIL rst_mem_addr: got %h, required 0", bus.mem_addr); end
    if (bus.mem_wdata  !== 8'h0)  begin errors++; $display("FAIL rst_mem_wdata: got %h, required 0", bus.mem_wdata); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word_store();
    int w0, acc;
    w0 = wr_cnt;
    issue(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0, 5, 1'b1, 1'b0, acc);
    wait_drain();
    checks++;
    if (wr_cnt - w0 != 4) begin
      errors++;
      $display("FAIL store_write_cycles: got %0d, required 4", wr_cnt - w0);
    end
    check_byte("store_b0", 8'h10, 8'hEF);
    check_byte("store_b1", 8'h11, 8'hBE);
    check_byte("store_b2", 8'h12, 8'hAD);
    check_byte("store_b3", 8'h13, 8'hDE);
  endtask

  task automatic test_word_load();
    int w0, acc;
    w0 = wr_cnt;
    issue(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5, 1'b1, 1'b0, acc);
    wait_drain();
    checks++;
    if (wr_cnt != w0) begin
      errors++;
      $display("FAIL load_no_write: got %0d write cycles, required 0", wr_cnt - w0);
    end
  endtask

  task automatic test_byte_loads();
    int acc;
    mem[8'h50] = 8'h80;
    issue(1'b0, 2'd0, 1'b1, 8'h50, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1'b1, 1'b0, acc);
    issue(1'b0, 2'd0, 1'b0, 8'h50, 32'h0, 32'h00000080, 1'b0, 2, 1'b1, 1'b0, acc);
    issue(1'b0, 2'd1, 1'b0, 8'h10, 32'h0, 32'h0000BEEF, 1'b0, 3, 1'b1, 1'b0, acc);
    issue(1'b0, 2'd1, 1'b1, 8'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 3, 1'b1, 1'b0, acc);
    wait_drain();
  endtask

  task automatic test_misaligned();
    int w0, acc;
    w0 = wr_cnt;
    issue(1'b1, 2'd2, 1'b0, 8'h11, 32'h12345678, 32'h0, 1'b1, 1, 1'b1, 1'b0, acc);
    issue(1'b1, 2'd1, 1'b0, 8'h21, 32'h0000CAFE, 32'h0, 1'b1, 1, 1'b1, 1'b0, acc);
    issue(1'b1, 2'd3, 1'b0, 8'h00, 32'hA5A5A5A5, 32'h0, 1'b1, 1, 1'b1, 1'b0, acc);
    issue(1'b0, 2'd2, 1'b1, 8'h12, 32'h0, 32'h0, 1'b1, 1, 1'b1, 1'b0, acc);
    wait_drain();
    checks++;
    if (wr_cnt != w0) begin
      errors++;
      $display("FAIL err_no_write: got %0d write cycles, required 0", wr_cnt - w0);
    end
    check_byte("err_mem_11", 8'h11, 8'hBE);
    check_byte("err_mem_12", 8'h12, 8'hAD);
    check_byte("err_mem_13", 8'h13, 8'hDE);
    check_byte("err_mem_14", 8'h14, 8'h00);
    check_byte("err_mem_21", 8'h21, 8'h00);
    check_byte("err_mem_22", 8'h22, 8'h00);
    check_byte("err_mem_00", 8'h00, 8'h00);
  endtask

  task automatic test_reset_mid_store();
    int r0, acc;
    mem[8'h42] = 8'hA5;
    mem[8'h43] = 8'h5A;
    r0 = resp_cnt;
    issue(1'b1, 2'd2, 1'b0, 8'h40, 32'h11223344, 32'h0, 1'b0, 0, 1'b0, 1'b0, acc);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks += 2;
    if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL midrst_mem_write: got %b, required 0", bus.mem_write); end
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL midrst_req_ready: got %b, required 1", bus.req_ready); end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL midrst_hold_ready: got %b, required 1", bus.req_ready); end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checks += 2;
    if (resp_cnt != r0) begin errors++; $display("FAIL midrst_no_resp: got %0d responses, required 0", resp_cnt - r0); end
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL midrst_after_ready: got %b, required 1", bus.req_ready); end
    check_byte("midrst_40", 8'h40, 8'h44);
    check_byte("midrst_41", 8'h41, 8'h33);
    check_byte("midrst_42", 8'h42, 8'hA5);
    check_byte("midrst_43", 8'h43, 8'h5A);
  endtask

  task automatic test_back_to_back();
    int w0, acc1, acc2;
    w0 = wr_cnt;
    issue(1'b1, 2'd1, 1'b0, 8'h30, 32'h0000BEEF, 32'h0, 1'b0, 3, 1'b1, 1'b1, acc1);
    issue(1'b0, 2'd1, 1'b1, 8'h30, 32'h0, 32'hFFFFBEEF, 1'b0, 3, 1'b1, 1'b0, acc2);
    wait_drain();
    checks++;
    if (acc2 - acc1 != 4) begin
      errors++;
      $display("FAIL b2b_accept_gap: got %0d cycles, required 4", acc2 - acc1);
    end
    checks++;
    if (wr_cnt - w0 != 2) begin
      errors++;
      $display("FAIL b2b_write_cycles: got %0d, required 2", wr_cnt - w0);
    end
    check_byte("b2b_30", 8'h30, 8'hEF);
    check_byte("b2b_31", 8'h31, 8'hBE);
  endtask

  initial begin
    cyc            = 0;
    checks         = 0;
    errors         = 0;
    wr_cnt         = 0;
    resp_cnt       = 0;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 8'h00;
    bus.req_wdata  = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    test_reset();
    test_word_store();
    test_word_load();
    test_byte_loads();
    test_misaligned();
    test_reset_mid_store();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
